// File: rtl/led_bank_if.sv
// CPU bus as seen by the LED bank: address, write strobe and a shared tri-state data bus.
interface led_bank_if;
    logic [7:0] addr;
    logic       we;
    wire  [7:0] data;

    modport master (output addr, output we, inout data);
    modport slave  (input addr, input we, inout data);
endinterface

// File: rtl/led_bank.sv
// Memory-mapped LED bank: NUM_BYTES data registers plus mode, PWM duty and blink period,
// with registered readback and a gated, registered LED output.
module led_bank #(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         NUM_BYTES = 2,
    parameter int         PWM_BITS  = 8,
    parameter int         TICK_DIV  = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_bank_if.slave              bus,
    output logic [8*NUM_BYTES-1:0] led
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [7:0]            data_reg [NUM_BYTES];
    logic [1:0]            mode_reg;
    logic [PWM_BITS-1:0]   duty_reg;
    logic [7:0]            period_reg;
    logic [PW-1:0]         presc_reg;
    logic [7:0]            tcnt_reg;
    logic                  phase_reg;
    logic [PWM_BITS-1:0]   pwm_reg;
    logic                  oe_reg;
    logic [7:0]            rdata_reg;
    logic [8*NUM_BYTES-1:0] led_reg;

    logic [7:0]             off;
    logic                   in_range;
    logic                   wr;
    logic                   wr_mode;
    logic                   wr_duty;
    logic                   wr_period;
    logic                   restart;
    logic                   tick;
    logic                   gate;
    logic [NUM_BYTES-1:0]   wr_data;
    logic [8*NUM_BYTES-1:0] data_flat;
    logic [7:0]             rd_val;

    assign off       = bus.addr - BASE_ADDR;
    assign in_range  = (bus.addr >= BASE_ADDR) && (off < 8'(NUM_BYTES + 3));
    assign wr        = bus.we && in_range;
    assign wr_mode   = wr && (off == 8'(NUM_BYTES));
    assign wr_duty   = wr && (off == 8'(NUM_BYTES + 1));
    assign wr_period = wr && (off == 8'(NUM_BYTES + 2));
    assign restart   = wr_mode || wr_period;
    assign tick      = (presc_reg == PW'(TICK_DIV - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            assign wr_data[gi]             = wr && (off == 8'(gi));
            assign data_flat[8*gi +: 8]    = data_reg[gi];
        end
    endgenerate

    always_comb begin
        rd_val = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (off == 8'(k)) rd_val = data_reg[k];
        end
        if (off == 8'(NUM_BYTES))     rd_val = {6'b0, mode_reg};
        if (off == 8'(NUM_BYTES + 1)) rd_val = 8'(duty_reg);
        if (off == 8'(NUM_BYTES + 2)) rd_val = period_reg;
    end

    // All-ones duty is a full-on special case; counter < duty alone would drop one cycle.
    always_comb begin
        gate = 1'b1;
        case (mode_reg)
            2'b00: gate = 1'b1;
            2'b01: gate = (&duty_reg) || (pwm_reg < duty_reg);
            2'b10: gate = phase_reg;
            2'b11: gate = ((&duty_reg) || (pwm_reg < duty_reg)) && phase_reg;
            default: gate = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BYTES; k++) data_reg[k] <= 8'h00;
            mode_reg   <= 2'b00;
            duty_reg   <= '1;
            period_reg <= 8'h00;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_data[k]) data_reg[k] <= bus.data;
            end
            if (wr_mode)   mode_reg   <= bus.data[1:0];
            if (wr_duty)   duty_reg   <= bus.data[PWM_BITS-1:0];
            if (wr_period) period_reg <= bus.data;
        end
    end

    // Read data reflects register contents before any write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_reg    <= 1'b0;
            rdata_reg <= 8'h00;
        end else begin
            oe_reg    <= !bus.we && in_range;
            rdata_reg <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            tcnt_reg  <= 8'h00;
            phase_reg <= 1'b1;
        end else if (restart) begin
            presc_reg <= '0;
            tcnt_reg  <= 8'h00;
            phase_reg <= 1'b1;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick && (period_reg != 8'h00)) begin
                if (tcnt_reg == period_reg - 8'd1) begin
                    tcnt_reg  <= 8'h00;
                    phase_reg <= !phase_reg;
                end else begin
                    tcnt_reg  <= tcnt_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= '0;
            led_reg <= '0;
        end else begin
            pwm_reg <= pwm_reg + PWM_BITS'(1);
            led_reg <= data_flat & {(8*NUM_BYTES){gate}};
        end
    end

    assign led      = led_reg;
    assign bus.data = oe_reg ? rdata_reg : 8'bz;
endmodule

// File: tb/tb_led_bank.sv
// Directed bench for led_bank with a short blink tick (TICK_DIV=4).
module tb_led_bank;
    logic        clk;
    logic        rst_n;
    logic [15:0] led;
    logic        drv;
    logic [7:0]  wdata;
    int          tests_run;
    int          tests_failed;

    led_bank_if bus ();

    assign bus.data = drv ? wdata : 8'bz;

    led_bank #(
        .BASE_ADDR(8'hC0),
        .NUM_BYTES(2),
        .PWM_BITS (8),
        .TICK_DIV (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .led  (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write lands on the posedge inside; returns at the following negedge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b1;
        wdata    = d;
        drv      = 1'b1;
        @(negedge clk);
        bus.we   = 1'b0;
        drv      = 1'b0;
        bus.addr = 8'h00;
        $display("[TB] write %02h <- %02h", a, d);
    endtask

    // Returns 1 ns after the addressing edge, with the read response on the bus.
    task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic oe);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b0;
        @(posedge clk);
        #1;
        v  = bus.data;
        oe = dut.oe_reg;
        bus.addr = 8'h00;
        $display("[TB] read  %02h -> %02h (driven=%0d)", a, v, oe);
    endtask

    task automatic test_reset;
        #50;
        tests_run++;
        if (led !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_led: got %04h want 0000", led);
        end
        tests_run++;
        if (dut.oe_reg !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_bus_hiz: driven=%0d want 0", dut.oe_reg);
        end
        #50;
        rst_n = 1'b1;
    endtask

    task automatic test_static;
        wr(8'hC0, 8'hFF);
        @(negedge clk);
        tests_run++;
        if (led !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL static_byte0: got %04h want 00FF", led);
        end
        wr(8'hC1, 8'hF0);
        @(negedge clk);
        tests_run++;
        if (led !== 16'hF0FF) begin
            tests_failed++;
            $display("FAIL static_byte1: got %04h want F0FF", led);
        end
    endtask

    task automatic test_readback;
        logic [7:0] v;
        logic       oe;
        logic [7:0] exp_regs [5];
        wr(8'hC1, 8'h5A);
        rd(8'hC1, v, oe);
        tests_run++;
        if (oe !== 1'b1 || v !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_c1: got %02h driven=%0d want 5A driven=1", v, oe);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (dut.oe_reg !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_release: driven=%0d want 0", dut.oe_reg);
        end
        rd(8'hC5, v, oe);
        tests_run++;
        if (oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_out_of_range: driven=%0d want 0", oe);
        end
        wr(8'hC7, 8'h33);
        exp_regs = '{8'hFF, 8'h5A, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 5; i++) begin
            rd(8'hC0 + 8'(i), v, oe);
            tests_run++;
            if (oe !== 1'b1 || v !== exp_regs[i]) begin
                tests_failed++;
                $display("FAIL regs_after_c7_write[%0d]: got %02h driven=%0d want %02h", i, v, oe, exp_regs[i]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (led !== 16'h5AFF) begin
            tests_failed++;
            $display("FAIL led_after_readback: got %04h want 5AFF", led);
        end
    endtask

    task automatic test_pwm;
        int on_cnt;
        int exp_on [3];
        logic [7:0] duties [3];
        wr(8'hC0, 8'hFF);
        wr(8'hC1, 8'hFF);
        wr(8'hC2, 8'h01);
        duties = '{8'h40, 8'h00, 8'hFF};
        exp_on = '{64, 0, 256};
        for (int d = 0; d < 3; d++) begin
            wr(8'hC3, duties[d]);
            on_cnt = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                if (led === 16'hFFFF) on_cnt++;
            end
            $display("[TB] pwm duty %02h: %0d of 256 cycles on", duties[d], on_cnt);
            tests_run++;
            if (on_cnt != exp_on[d]) begin
                tests_failed++;
                $display("FAIL pwm_duty_%02h: on cycles %0d want %0d", duties[d], on_cnt, exp_on[d]);
            end
        end
    endtask

    task automatic test_blink;
        logic [15:0] exp;
        wr(8'hC4, 8'h03);
        wr(8'hC2, 8'h02);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            exp = (((n - 1) / 12) % 2 == 0) ? 16'hFFFF : 16'h0000;
            tests_run++;
            if (led !== exp) begin
                tests_failed++;
                $display("FAIL blink_cycle_%0d: got %04h want %04h", n, led, exp);
            end
        end
        for (int n = 37; n <= 42; n++) @(negedge clk);
        tests_run++;
        if (led !== 16'h0000) begin
            tests_failed++;
            $display("FAIL blink_mid_off: got %04h want 0000", led);
        end
        wr(8'hC4, 8'h00);
        @(negedge clk);
        for (int n = 0; n < 30; n++) begin
            tests_run++;
            if (led !== 16'hFFFF) begin
                tests_failed++;
                $display("FAIL blink_period0_hold_%0d: got %04h want FFFF", n, led);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blink_pwm;
        int on_cnt;
        int zero_cnt;
        wr(8'hC3, 8'h80);
        wr(8'hC4, 8'h40);
        wr(8'hC2, 8'h03);
        on_cnt   = 0;
        zero_cnt = 0;
        for (int n = 1; n <= 256; n++) begin
            @(negedge clk);
            if (led === 16'hFFFF) on_cnt++;
            if (led === 16'h0000) zero_cnt++;
        end
        $display("[TB] blink+pwm on phase: %0d on, %0d off", on_cnt, zero_cnt);
        tests_run++;
        if (on_cnt != 128 || zero_cnt != 128) begin
            tests_failed++;
            $display("FAIL blink_pwm_on_phase: on %0d off %0d want 128 128", on_cnt, zero_cnt);
        end
        zero_cnt = 0;
        for (int n = 257; n <= 512; n++) begin
            @(negedge clk);
            if (led === 16'h0000) zero_cnt++;
        end
        $display("[TB] blink+pwm off phase: %0d of 256 cycles dark", zero_cnt);
        tests_run++;
        if (zero_cnt != 256) begin
            tests_failed++;
            $display("FAIL blink_pwm_off_phase: dark %0d want 256", zero_cnt);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [7:0] v;
        logic       oe;
        logic [7:0] exp_regs [5];
        wr(8'hC4, 8'h03);
        wr(8'hC2, 8'h02);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (led !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL pre_reset_on: got %04h want FFFF", led);
        end
        rd(8'hC0, v, oe);
        tests_run++;
        if (oe !== 1'b1 || v !== 8'hFF) begin
            tests_failed++;
            $display("FAIL pre_reset_read: got %02h driven=%0d want FF driven=1", v, oe);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (led !== 16'h0000 || dut.oe_reg !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: led %04h driven=%0d want 0000 driven=0", led, dut.oe_reg);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset pulse done");
        exp_regs = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 5; i++) begin
            rd(8'hC0 + 8'(i), v, oe);
            tests_run++;
            if (oe !== 1'b1 || v !== exp_regs[i]) begin
                tests_failed++;
                $display("FAIL post_reset_reg[%0d]: got %02h driven=%0d want %02h", i, v, oe, exp_regs[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        bus.addr = 8'h00;
        bus.we   = 1'b0;
        drv      = 1'b0;
        wdata    = 8'h00;
        test_reset;
        test_static;
        test_readback;
        test_pwm;
        test_blink;
        test_blink_pwm;
        test_reset_mid_op;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/led_bank.md
# led_bank

Memory-mapped LED output peripheral on the CPU bus and the parametrised successor to the fixed two-byte LED block. It holds `NUM_BYTES` bytes of LED state at consecutive bus addresses from `BASE_ADDR`, and supports register readback. It adds a global PWM brightness control and a timed blink mode.

## Interface
- `BASE_ADDR`, default 8'hC0: address of LED byte 0.
- `NUM_BYTES`, default 2: number of LED bytes (1..8).
- `PWM_BITS`, default 8: width of the PWM counter and the duty register (≤8).
- `TICK_DIV`, default 1_000_000: clock cycles per blink tick (10 ms at 100 MHz).

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `BUS_ADDR`  in  8  CPU bus address.
- `BUS_DATA`  inout  8  CPU bus data; driven by this block only during its read response.
- `BUS_WE`  in  1  CPU write enable, high for one cycle per write.
- `LED`  out  8*NUM_BYTES  LED drive; byte k is `LED[8k+7:8k]`.

## Operation
Register map, with offsets from `BASE_ADDR`:
- 0..NUM_BYTES-1: `DATA[k]`, the LED pattern.
- NUM_BYTES: `MODE[1:0]`. 00 static, 01 PWM, 10 blink, 11 blink+PWM. Upper bits are read as 0.
- NUM_BYTES+1: `DUTY`, the PWM duty. The low `PWM_BITS` bits are used.
- NUM_BYTES+2: `PERIOD`, the blink half-period in ticks.

Writes:
- A rising edge with `BUS_WE`=1 and `BUS_ADDR` in range stores `BUS_DATA` into the addressed register.
- Out-of-range addresses are ignored.

Reads:
- A rising edge with `BUS_WE`=0 and `BUS_ADDR` in range latches the register value and sets an internal drive enable.
- For the next cycle only, `BUS_DATA` carries that value. Otherwise `BUS_DATA` is high-Z.

Tick prescaler:
- A counter runs from 0 to `TICK_DIV`-1 and wraps.
- It pulses `tick` for one cycle at wrap.

Blink:
- The phase flag starts at ON.
- A tick counter increments on each `tick`. When it reaches `PERIOD`-1, it clears to 0 and the phase toggles.
- `PERIOD`=0 freezes the phase at ON.
- A write to `PERIOD` or `MODE` clears the tick counter, the prescaler and the phase (phase returns to ON).

PWM:
- A free-running `PWM_BITS` counter runs with no dependency on mode.
- Gate is on when counter < `DUTY`.
- `DUTY`=all-ones forces the gate on continuously.
- `DUTY`=0 keeps the gate off.

Output:
- Gate G depends on mode: 00 → 1; 01 → pwm; 10 → phase; 11 → pwm AND phase.
- `LED` <= {`DATA`} AND replicated G, registered.

Reset, asserted at any time including mid-blink or mid-read:
- `DATA`=0, `MODE`=0, `DUTY`=all-ones, `PERIOD`=0.
- All counters are 0, phase is ON, `LED`=0, `BUS_DATA` is high-Z.

## Timing
- A write at edge N is visible on `LED` after edge N+1, a latency of 1 cycle. The same applies to mode, duty and period changes.
- A read addressed at edge N is driven on `BUS_DATA` between edges N and N+1. The value is the register contents before any write at edge N.
- Back-to-back accesses, one per cycle, are supported with no stall.
- PWM period is 2^`PWM_BITS` cycles (256 at default).
- Blink full period is 2·`PERIOD`·`TICK_DIV` cycles.
- The first toggle after a `MODE`/`PERIOD` write or reset happens `PERIOD`·`TICK_DIV` cycles later.
- Asynchronous reset takes effect immediately. Release is sampled on the next edge.

## Test plan
- **Reset and static write** (`TICK_DIV`=4). Hold `RESET` low for 100 ns. Then write C0←FF and C1←F0.
  - During reset, `LED`=0000.
  - One cycle after each write, `LED`=00FF, then F0FF.
- **Readback**:
  - Write C1←5A, then read C1: `BUS_DATA`=5A for exactly one cycle, then high-Z.
  - Read C5 (out of range): `BUS_DATA` stays high-Z.
  - Write C7←33: no register changes.
- **PWM**. Set `DATA`=FFFF, `MODE` (C2)←01.
  - `DUTY` (C3)←40: `LED`=FFFF for 64 of every 256 cycles.
  - `DUTY`←00: `LED` is always 0.
  - `DUTY`←FF: `LED` is always FFFF.
- **Blink**. Set `TICK_DIV`=4, `PERIOD` (C4)←3, `MODE`←10.
  - `LED` alternates FFFF/0000 with 12-cycle halves, starting ON.
  - Writing `PERIOD`←0 mid-OFF returns `LED` to FFFF one cycle after the write and holds it there.
- **Blink+PWM**. Set `MODE`←11, `DUTY`←80.
  - In ON phases, `LED` has a 50% duty.
  - In OFF phases, `LED`=0.
- **Reset mid-operation**. Pulse `RESET` low during the blink ON phase with a read pending.
  - `LED`=0 and `BUS_DATA` is high-Z immediately.
  - After reset, the registers read back 00, 00, 00, FF, 00.
